// File: rtl/instr_enc_pkg.sv
// Shared types, opcode constants and helpers for the micro-op instruction encoder.
package instr_enc_pkg;

   localparam int unsigned INSTR_W = 18;
   localparam int unsigned OPC_W   = 11;
   localparam int unsigned RD_W    = 5;

   typedef enum logic [4:0] {
      OP_NOP   = 5'd0,
      OP_ADDI  = 5'd1,
      OP_SUBS  = 5'd2,
      OP_SUB   = 5'd3,
      OP_ADDS  = 5'd4,
      OP_ADD   = 5'd5,
      OP_AND   = 5'd6,
      OP_ORR   = 5'd7,
      OP_EOR   = 5'd8,
      OP_B     = 5'd9,
      OP_CBZ   = 5'd10,
      OP_BCOND = 5'd11,
      OP_STUR  = 5'd12,
      OP_LDUR  = 5'd13,
      OP_BL    = 5'd14,
      OP_BR    = 5'd15,
      OP_LSR   = 5'd16,
      OP_LSL   = 5'd17,
      OP_MUL   = 5'd18,
      OP_DIV   = 5'd19
   } op_kind_t;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_BR_WAIT = 1'b1
   } fsm_state_t;

   typedef struct packed {
      logic [5:0]       rd;
      logic             zero;
      logic [OPC_W-1:0] opc;
   } instr_word_t;

   localparam logic [OPC_W-1:0] OPC_ADDI  = 11'b10010001000;
   localparam logic [OPC_W-1:0] OPC_SUBS  = 11'b11101011000;
   localparam logic [OPC_W-1:0] OPC_SUB   = 11'b11001011000;
   localparam logic [OPC_W-1:0] OPC_ADDS  = 11'b10101011000;
   localparam logic [OPC_W-1:0] OPC_ADD   = 11'b10001011000;
   localparam logic [OPC_W-1:0] OPC_AND   = 11'b10001010000;
   localparam logic [OPC_W-1:0] OPC_ORR   = 11'b10101010000;
   localparam logic [OPC_W-1:0] OPC_EOR   = 11'b11001010000;
   localparam logic [OPC_W-1:0] OPC_B     = 11'b00010100000;
   localparam logic [OPC_W-1:0] OPC_CBZ   = 11'b10110100000;
   localparam logic [OPC_W-1:0] OPC_BCOND = 11'b01010100000;
   localparam logic [OPC_W-1:0] OPC_STUR  = 11'b11111000000;
   localparam logic [OPC_W-1:0] OPC_LDUR  = 11'b11111000010;
   localparam logic [OPC_W-1:0] OPC_BL    = 11'b10010100000;
   localparam logic [OPC_W-1:0] OPC_BR    = 11'b11010110000;
   localparam logic [OPC_W-1:0] OPC_LSR   = 11'b11010011010;
   localparam logic [OPC_W-1:0] OPC_LSL   = 11'b11010011011;
   localparam logic [OPC_W-1:0] OPC_MUL   = 11'b10011011000;
   localparam logic [OPC_W-1:0] OPC_DIV   = 11'b10011010110;
   localparam logic [OPC_W-1:0] OPC_NOP   = 11'b00000000000;

   localparam logic [RD_W-1:0] LINK_REG = 5'b11110;

   // Unknown op kinds map to the all-zero NOP opcode.
   function automatic logic [OPC_W-1:0] opcode_of(input logic [4:0] op);
      logic [OPC_W-1:0] opc;
      case (op)
         OP_ADDI:  opc = OPC_ADDI;
         OP_SUBS:  opc = OPC_SUBS;
         OP_SUB:   opc = OPC_SUB;
         OP_ADDS:  opc = OPC_ADDS;
         OP_ADD:   opc = OPC_ADD;
         OP_AND:   opc = OPC_AND;
         OP_ORR:   opc = OPC_ORR;
         OP_EOR:   opc = OPC_EOR;
         OP_B:     opc = OPC_B;
         OP_CBZ:   opc = OPC_CBZ;
         OP_BCOND: opc = OPC_BCOND;
         OP_STUR:  opc = OPC_STUR;
         OP_LDUR:  opc = OPC_LDUR;
         OP_BL:    opc = OPC_BL;
         OP_BR:    opc = OPC_BR;
         OP_LSR:   opc = OPC_LSR;
         OP_LSL:   opc = OPC_LSL;
         OP_MUL:   opc = OPC_MUL;
         OP_DIV:   opc = OPC_DIV;
         default:  opc = OPC_NOP;
      endcase
      return opc;
   endfunction

   // Branch class is recognised from the stored opcode field of a queued word.
   function automatic logic is_branch(input logic [OPC_W-1:0] opc);
      return (opc == OPC_B) || (opc == OPC_CBZ) || (opc == OPC_BCOND) ||
             (opc == OPC_BL) || (opc == OPC_BR);
   endfunction

endpackage

// File: rtl/enc_fifo.sv
// DEPTH x W synchronous FIFO with flush, occupancy count and full/empty flags.
module enc_fifo
   import instr_enc_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = INSTR_W,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     wdata,
   output logic [W-1:0]     rdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   // Storage is cleared on reset so the head word reads as zero when empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end else if (do_push && !flush) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_encode_queue.sv
// Micro-op encoder, output FIFO and branch fence FSM.
// Build option: define ENC_ILLEGAL_TRAP_EN to drop unknown op kinds and raise sticky illegal_o.
module instr_encode_queue
   import instr_enc_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [4:0]         req_op_i,
   input  logic [4:0]         req_rd_i,
   output logic               instr_valid_o,
   input  logic               instr_ready_i,
   output logic [INSTR_W-1:0] instr_o,
`ifdef ENC_ILLEGAL_TRAP_EN
   output logic               illegal_o,
`endif
   input  logic               br_resolve_i,
   input  logic               br_flush_i,
   output logic               fenced_o,
   output logic [PTR_W:0]     count_o
);

   instr_word_t  enc;
   instr_word_t  head;
   fsm_state_t   state;
   fsm_state_t   state_nxt;
   logic         full;
   logic         empty;
   logic         pop;
   logic         push;
   logic         accept;
   logic         known_op;

   assign known_op = (req_op_i <= OP_DIV);

   // Encoder: rd is forced for link/unconditional ops and unknown kinds encode as zero.
   always_comb begin
      enc      = '0;
      enc.opc  = opcode_of(req_op_i);
      enc.zero = 1'b0;
      case (req_op_i)
         OP_BL:               enc.rd = {1'b0, LINK_REG};
         OP_B, OP_BR, OP_NOP: enc.rd = '0;
         default:             enc.rd = known_op ? {1'b0, req_rd_i} : '0;
      endcase
   end

   assign instr_valid_o = ~empty & (state == ST_RUN) & ~br_flush_i;
   assign pop           = instr_valid_o & instr_ready_i;
   assign req_ready_o   = (~full | pop) & ~br_flush_i;
   assign accept        = req_valid_i & req_ready_o;
   assign instr_o       = head;
   assign fenced_o      = (state == ST_BR_WAIT);

`ifdef ENC_ILLEGAL_TRAP_EN
   assign push = accept & known_op;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  illegal_o <= 1'b0;
      else if (accept && !known_op) illegal_o <= 1'b1;
   end
`else
   assign push = accept;
`endif

   enc_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (br_flush_i),
      .push  (push),
      .pop   (pop),
      .wdata (enc),
      .rdata (head),
      .count (count_o),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_RUN;
      else       state <= state_nxt;
   end

   // Fence after a popped branch until resolve; flush always wins.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN: begin
            if (!br_flush_i && pop && is_branch(head.opc)) state_nxt = ST_BR_WAIT;
         end
         ST_BR_WAIT: begin
            if (br_flush_i || br_resolve_i) state_nxt = ST_RUN;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

endmodule

// File: tb/tb_instr_encode_queue.sv
// Directed, table-driven self-checking bench for instr_encode_queue.
module tb_instr_encode_queue;
   import instr_enc_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned NVEC  = 14;

   typedef struct {
      logic [4:0]  op;
      logic [4:0]  rd;
      logic [17:0] exp;
      logic        br;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  req_op = '0;
   logic [4:0]  req_rd = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [17:0] instr;
   logic        br_resolve = 1'b0;
   logic        br_flush = 1'b0;
   logic        fenced;
   logic [2:0]  count;
`ifdef ENC_ILLEGAL_TRAP_EN
   logic        illegal;
`endif

   int errors = 0;
   int checks = 0;
   vec_t vecs [NVEC];

   instr_encode_queue #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_op_i      (req_op),
      .req_rd_i      (req_rd),
      .instr_valid_o (instr_valid),
      .instr_ready_i (instr_ready),
      .instr_o       (instr),
`ifdef ENC_ILLEGAL_TRAP_EN
      .illegal_o     (illegal),
`endif
      .br_resolve_i  (br_resolve),
      .br_flush_i    (br_flush),
      .fenced_o      (fenced),
      .count_o       (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_op(input logic [4:0] op, input logic [4:0] rd);
      req_valid = 1'b1;
      req_op    = op;
      req_rd    = rd;
      tick();
      req_valid = 1'b0;
   endtask

   function automatic logic [17:0] add_word(input int k);
      return {1'b0, 5'(k), 1'b0, 11'b10001011000};
   endfunction

   initial begin
      vecs[0]  = '{OP_ADD,   5'd3,      {6'b000011, 1'b0, 11'b10001011000}, 1'b0};
      vecs[1]  = '{OP_ADDI,  5'd1,      {6'b000001, 1'b0, 11'b10010001000}, 1'b0};
      vecs[2]  = '{OP_SUBS,  5'd2,      {6'b000010, 1'b0, 11'b11101011000}, 1'b0};
      vecs[3]  = '{OP_BL,    5'd7,      {6'b011110, 1'b0, 11'b10010100000}, 1'b1};
      vecs[4]  = '{OP_B,     5'd5,      {6'b000000, 1'b0, 11'b00010100000}, 1'b1};
      vecs[5]  = '{OP_BR,    5'd9,      {6'b000000, 1'b0, 11'b11010110000}, 1'b1};
      vecs[6]  = '{OP_NOP,   5'd4,      18'd0,                              1'b0};
      vecs[7]  = '{OP_BCOND, 5'b01011,  {6'b001011, 1'b0, 11'b01010100000}, 1'b1};
      vecs[8]  = '{OP_LDUR,  5'd31,     {6'b011111, 1'b0, 11'b11111000010}, 1'b0};
      vecs[9]  = '{OP_MUL,   5'd16,     {6'b010000, 1'b0, 11'b10011011000}, 1'b0};
      vecs[10] = '{OP_DIV,   5'd0,      {6'b000000, 1'b0, 11'b10011010110}, 1'b0};
      vecs[11] = '{OP_LSL,   5'd12,     {6'b001100, 1'b0, 11'b11010011011}, 1'b0};
      vecs[12] = '{OP_EOR,   5'd8,      {6'b001000, 1'b0, 11'b11001010000}, 1'b0};
      vecs[13] = '{OP_CBZ,   5'd2,      {6'b000010, 1'b0, 11'b10110100000}, 1'b1};

      // Reset state
      repeat (2) tick();
      reset = 1'b0;
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_fenced", 32'(fenced), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
`ifdef ENC_ILLEGAL_TRAP_EN
      chk("rst_illegal", 32'(illegal), 32'd0);
`endif
      tick();

      // Single-op encode, present, pop, fence check
      for (int i = 0; i < int'(NVEC); i++) begin
         chk("vec_req_ready", 32'(req_ready), 32'd1);
         push_op(vecs[i].op, vecs[i].rd);
         chk("vec_valid", 32'(instr_valid), 32'd1);
         chk("vec_instr", 32'(instr), 32'(vecs[i].exp));
         chk("vec_count1", 32'(count), 32'd1);
         instr_ready = 1'b1;
         tick();
         instr_ready = 1'b0;
         chk("vec_count0", 32'(count), 32'd0);
         chk("vec_fenced", 32'(fenced), 32'(vecs[i].br));
         if (vecs[i].br) begin
            br_resolve = 1'b1;
            tick();
            br_resolve = 1'b0;
            chk("vec_unfence", 32'(fenced), 32'd0);
         end
      end

      // BL fences a queued ADD until resolve
      push_op(OP_BL, 5'd7);
      push_op(OP_ADD, 5'd3);
      chk("bl_count2", 32'(count), 32'd2);
      chk("bl_head", 32'(instr), 32'({6'b011110, 1'b0, 11'b10010100000}));
      instr_ready = 1'b1;
      tick();
      chk("bl_fenced", 32'(fenced), 32'd1);
      chk("bl_held_valid", 32'(instr_valid), 32'd0);
      chk("bl_count1", 32'(count), 32'd1);
      tick();
      chk("bl_still_held", 32'(count), 32'd1);
      br_resolve = 1'b1;
      tick();
      br_resolve = 1'b0;
      chk("bl_resolved", 32'(fenced), 32'd0);
      chk("bl_add_valid", 32'(instr_valid), 32'd1);
      chk("bl_add_instr", 32'(instr), 32'(add_word(3)));
      tick();
      instr_ready = 1'b0;
      chk("bl_drained", 32'(count), 32'd0);

      // Fill, full push+pop, ordering across wrap
      for (int k = 1; k <= 4; k++) push_op(OP_ADD, 5'(k));
      chk("fill_count", 32'(count), 32'd4);
      chk("fill_ready", 32'(req_ready), 32'd0);
      for (int j = 0; j < 8; j++) begin
         instr_ready = 1'b1;
         req_valid   = (j < 4);
         req_op      = OP_ADD;
         req_rd      = 5'(j + 5);
         #1;
         chk("wrap_valid", 32'(instr_valid), 32'd1);
         chk("wrap_instr", 32'(instr), 32'(add_word(j + 1)));
         if (j < 4) chk("wrap_full_ready", 32'(req_ready), 32'd1);
         tick();
         chk("wrap_count", 32'(count), (j < 4) ? 32'd4 : 32'(7 - j));
      end
      instr_ready = 1'b0;
      req_valid   = 1'b0;

      // Flush during fence with coincident push and resolve
      push_op(OP_CBZ, 5'd2);
      for (int k = 1; k <= 3; k++) push_op(OP_ADD, 5'(k));
      chk("fl_count4", 32'(count), 32'd4);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk("fl_fenced", 32'(fenced), 32'd1);
      chk("fl_count3", 32'(count), 32'd3);
      br_flush   = 1'b1;
      br_resolve = 1'b1;
      req_valid  = 1'b1;
      req_op     = OP_ADD;
      req_rd     = 5'd21;
      instr_ready = 1'b1;
      #1;
      chk("fl_req_ready", 32'(req_ready), 32'd0);
      chk("fl_valid_forced", 32'(instr_valid), 32'd0);
      tick();
      br_flush    = 1'b0;
      br_resolve  = 1'b0;
      req_valid   = 1'b0;
      instr_ready = 1'b0;
      chk("fl_count0", 32'(count), 32'd0);
      chk("fl_unfenced", 32'(fenced), 32'd0);
      chk("fl_valid0", 32'(instr_valid), 32'd0);
      tick();
      chk("fl_no_ghost", 32'(count), 32'd0);
      push_op(OP_ADDI, 5'd6);
      chk("fl_next_instr", 32'(instr), 32'({6'b000110, 1'b0, 11'b10010001000}));
      chk("fl_next_count", 32'(count), 32'd1);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;

      // Asynchronous reset while fenced
      push_op(OP_BCOND, 5'b01011);
      push_op(OP_ADD, 5'd9);
      chk("ar_bcond", 32'(instr), 32'({6'b001011, 1'b0, 11'b01010100000}));
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk("ar_fenced", 32'(fenced), 32'd1);
      chk("ar_count1", 32'(count), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("ar_fenced0", 32'(fenced), 32'd0);
      chk("ar_count0", 32'(count), 32'd0);
      chk("ar_valid0", 32'(instr_valid), 32'd0);
      chk("ar_instr0", 32'(instr), 32'd0);
      chk("ar_ready1", 32'(req_ready), 32'd1);
      #1;
      reset = 1'b0;
      tick();

      // Unknown op kind 25
      push_op(5'd25, 5'd3);
`ifdef ENC_ILLEGAL_TRAP_EN
      chk("ill_flag", 32'(illegal), 32'd1);
      chk("ill_count", 32'(count), 32'd0);
      tick();
      chk("ill_sticky", 32'(illegal), 32'd1);
`else
      chk("unk_count", 32'(count), 32'd1);
      chk("unk_valid", 32'(instr_valid), 32'd1);
      chk("unk_instr", 32'(instr), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
